// File: rtl/adc_buf_pkg.sv
// Shared constants for the ADC result buffer: register offsets and field positions.
// Combinational definitions only; no latency or backpressure of its own.
package adc_buf_pkg;

  localparam int ADC_DATA_W  = 10;
  localparam int ACC_EXTRA_W = 3;
  localparam int TS_W        = 16;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_STATUS = 2'd1,
    REG_DATA   = 2'd2,
    REG_THRESH = 2'd3
  } reg_ofs_e;

  // CTRL fields
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CAL_BIT = 1;
  localparam int CTRL_AVG_LSB = 4;
  localparam int CTRL_AVG_W   = 2;
  localparam int CTRL_CLR_BIT = 8;

  // STATUS fields
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;

  // DATA word fields
  localparam int DATA_VLD_BIT = 15;
  localparam int DATA_TS_LSB  = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy level; pushes to a full FIFO are dropped and flagged.
// Latency: push visible on the next cycle, rdata shows the head combinationally.
// Backpressure: none; a push while full (without a same-cycle pop) raises overflow_pulse.
module sync_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow_pulse
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic                  do_push, do_pop;

  assign empty = (level == '0);
  assign full  = (level == (DEPTH_LOG2+1)'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_pop         = pop & ~empty & ~clear;
  assign do_push        = push & (~full | do_pop) & ~clear;
  assign overflow_pulse = push & full & ~do_pop & ~clear;

  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/adc_result_fifo_wb.sv
// ADC result capture with 2^k box-car averaging, FIFO buffering and a Wishbone slave port.
// Latency: sample to FIFO 1 cycle; Wishbone ack 1 cycle after request. Optional ADC_TIMESTAMP_EN.
// Backpressure: none toward the ADC; pushes into a full FIFO are dropped and set sticky overflow.
module adc_result_fifo_wb
  import adc_buf_pkg::*;
#(
  parameter int          DATA_W     = ADC_DATA_W,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [DATA_W-1:0] adc_result,
  input  logic              adc_valid,
  output logic              adc_en,
  output logic              adc_cal,
  output logic              irq
);

`ifdef ADC_TIMESTAMP_EN
  localparam int ENTRY_W = DATA_W + TS_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif
  localparam int ACC_W = DATA_W + ACC_EXTRA_W;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic                  req, acc_cyc, wr;
  reg_ofs_e              ofs;
  logic                  wr_ctrl_lo, wr_ctrl_hi, wr_stat_hi, wr_thr, pop;
  logic                  enable, ovf, rd_vld;
  logic [CTRL_AVG_W-1:0] avg_log2, new_avg;
  logic                  new_en, acc_rst, fifo_clr;
  logic [LVL_W-1:0]      thresh;
  logic [31:0]           rd_mux;

  logic [ACC_W-1:0]      acc, acc_sum;
  logic [2:0]            cnt, cnt_last;
  logic                  sample_in, push;
  logic [DATA_W-1:0]     push_sample;

  logic [ENTRY_W-1:0]    wdata, rdata;
  logic [LVL_W-1:0]      level;
  logic                  empty, full, ovf_pulse;

  assign req     = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign ofs     = reg_ofs_e'(wbs_adr_i[3:2]);
  assign acc_cyc = wbs_ack_o & req;
  assign wr      = acc_cyc & wbs_we_i;

  assign wr_ctrl_lo = wr & (ofs == REG_CTRL) & wbs_sel_i[0];
  assign wr_ctrl_hi = wr & (ofs == REG_CTRL) & wbs_sel_i[1];
  assign wr_stat_hi = wr & (ofs == REG_STATUS) & wbs_sel_i[1];
  assign wr_thr     = wr & (ofs == REG_THRESH) & wbs_sel_i[0];
  // Only pop an entry that was actually returned; a push landing mid-access must survive.
  assign pop        = acc_cyc & ~wbs_we_i & (ofs == REG_DATA) & rd_vld;

  assign new_en   = wbs_dat_i[CTRL_EN_BIT];
  assign new_avg  = wbs_dat_i[CTRL_AVG_LSB +: CTRL_AVG_W];
  assign acc_rst  = wr_ctrl_lo & ((new_avg != avg_log2) | (enable & ~new_en));
  assign fifo_clr = wr_ctrl_hi & wbs_dat_i[CTRL_CLR_BIT];

  assign sample_in   = adc_valid & enable;
  assign acc_sum     = acc + ACC_W'(adc_result);
  assign cnt_last    = 3'((4'd1 << avg_log2) - 4'd1);
  assign push        = sample_in & (cnt == cnt_last);
  assign push_sample = DATA_W'(acc_sum >> avg_log2);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || acc_rst || fifo_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (sample_in) begin
      if (push) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 3'd1;
      end
    end
  end

`ifdef ADC_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ts <= '0;
    end else if (wr_ctrl_lo && new_en && !enable) begin
      ts <= '0;
    end else if (sample_in) begin
      ts <= ts + 1'b1;
    end
  end

  assign wdata = {ts, push_sample};
`else
  assign wdata = push_sample;
`endif

  sync_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk            (wb_clk_i),
    .rst            (wb_rst_i),
    .push           (push),
    .pop            (pop),
    .clear          (fifo_clr),
    .wdata          (wdata),
    .rdata          (rdata),
    .level          (level),
    .empty          (empty),
    .full           (full),
    .overflow_pulse (ovf_pulse)
  );

  always_comb begin
    rd_mux = '0;
    case (ofs)
      REG_CTRL: begin
        rd_mux[CTRL_EN_BIT]                   = enable;
        rd_mux[CTRL_AVG_LSB +: CTRL_AVG_W]    = avg_log2;
      end
      REG_STATUS: begin
        rd_mux[LVL_W-1:0]     = level;
        rd_mux[STAT_EMPTY_BIT] = empty;
        rd_mux[STAT_FULL_BIT]  = full;
        rd_mux[STAT_OVF_BIT]   = ovf;
      end
      REG_DATA: begin
        if (!empty) begin
          rd_mux[DATA_W-1:0]   = rdata[DATA_W-1:0];
          rd_mux[DATA_VLD_BIT] = 1'b1;
`ifdef ADC_TIMESTAMP_EN
          rd_mux[DATA_TS_LSB +: TS_W] = rdata[ENTRY_W-1 -: TS_W];
`endif
        end
      end
      default: rd_mux[LVL_W-1:0] = thresh;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      rd_vld    <= 1'b0;
      enable    <= 1'b0;
      avg_log2  <= '0;
      thresh    <= '0;
      ovf       <= 1'b0;
      adc_cal   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      wbs_ack_o <= req & ~wbs_ack_o;
      wbs_dat_o <= (req && !wbs_ack_o) ? rd_mux : '0;
      rd_vld    <= req & ~wbs_ack_o & ~wbs_we_i & (ofs == REG_DATA) & ~empty;
      adc_cal   <= wr_ctrl_lo & wbs_dat_i[CTRL_CAL_BIT];
      if (wr_ctrl_lo) begin
        enable   <= new_en;
        avg_log2 <= new_avg;
      end
      if (wr_thr) thresh <= wbs_dat_i[LVL_W-1:0];
      if (ovf_pulse) ovf <= 1'b1;
      else if (wr_stat_hi && wbs_dat_i[STAT_OVF_BIT]) ovf <= 1'b0;
      irq <= (thresh != '0) && (level >= thresh);
    end
  end

  assign adc_en = enable;

  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i, wbs_adr_i[7:4], wbs_adr_i[1:0]};

endmodule
